// File: rtl/ibex_mem_arbiter_pkg.sv
// ibex_mem_arbiter_pkg
//   Shared types and helpers for the instruction/data memory arbiter.
//   - mem_src_e     : identifies which core interface owns a transaction.
//   - InstrBe       : byte enables presented for instruction fetches.
//   - mem_src_other : the opposite requester, used for round-robin ties.

package ibex_mem_arbiter_pkg;

    typedef enum logic {
        MemSrcInstr = 1'b0,
        MemSrcData  = 1'b1
    } mem_src_e;

    // Fetches always read a full word.
    localparam logic [3:0] InstrBe = 4'hF;

    function automatic mem_src_e mem_src_other(mem_src_e src);
        return (src == MemSrcData) ? MemSrcInstr : MemSrcData;
    endfunction

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// ibex_mem_arb_id_fifo
//   In-order FIFO recording the source of every granted memory transaction,
//   so each response can be returned to the requester that issued it.
//   Ports:
//     clk_i        clock
//     rst_i        synchronous active-high reset (flushes all entries)
//     push_i       write push_data_i at the tail (ignored when full)
//     push_data_i  entry to write
//     pop_i        drop the head entry (ignored when empty)
//     head_o       oldest entry; only meaningful when empty_o is low
//     full_o       Depth entries held
//     empty_o      no entries held

module ibex_mem_arb_id_fifo
    import ibex_mem_arbiter_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = mem_src_e
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    entry_t          storage_q [Depth];

    logic do_push;
    logic do_pop;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = storage_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry contents need no reset: they are only read while the count says valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
//   Shares one memory port between the Ibex instruction-fetch and data
//   interfaces. Round-robin arbitration, selection held until granted, and an
//   in-order ID FIFO that steers each response back to its requester.
//   Request and response paths are purely combinational (no added latency).
//   Ports:
//     clk_i, rst_i                  clock, synchronous active-high reset
//     instr_*                       fetch request in, grant/response out
//     data_*                        data request in, grant/response out
//     mem_req_o .. mem_wdata_intg_o shared request towards memory
//     mem_gnt_i .. mem_err_i        memory grant and response
//     protocol_err_o                sticky: response seen with nothing outstanding

module ibex_mem_arbiter
    import ibex_mem_arbiter_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ResetDataFirst = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [6:0]  mem_wdata_intg_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [6:0]  mem_rdata_intg_i,
    input  logic        mem_err_i,

    output logic        protocol_err_o
);

    // last_q starts as the loser of the first tie so the other side wins it.
    localparam mem_src_e ResetLast = ResetDataFirst ? MemSrcInstr : MemSrcData;

    mem_src_e last_q, last_d;
    mem_src_e lock_src_q, lock_src_d;
    logic     lock_q, lock_d;
    logic     perr_q, perr_d;

    mem_src_e sel_src;
    logic     sel_req;
    logic     grant;
    logic     fifo_full;
    logic     fifo_empty;
    mem_src_e fifo_head;
    logic     resp_valid;

    // ------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------
    always_comb begin
        // Tie (or no request): favour whoever was not granted last.
        sel_src = mem_src_other(last_q);
        if (lock_q) begin
            // An ungranted request must stay presented unchanged.
            sel_src = lock_src_q;
        end else if (data_req_i && !instr_req_i) begin
            sel_src = MemSrcData;
        end else if (instr_req_i && !data_req_i) begin
            sel_src = MemSrcInstr;
        end
    end

    assign sel_req = (sel_src == MemSrcData) ? data_req_i : instr_req_i;

    // A full FIFO blocks the request outright; a same-cycle pop does not
    // free a slot for it, keeping rvalid off the gnt/req path.
    assign mem_req_o   = sel_req & ~fifo_full & ~rst_i;
    assign grant       = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = grant & (sel_src == MemSrcInstr);
    assign data_gnt_o  = grant & (sel_src == MemSrcData);

    always_comb begin
        mem_addr_o       = instr_addr_i;
        mem_we_o         = 1'b0;
        mem_be_o         = InstrBe;
        mem_wdata_o      = '0;
        mem_wdata_intg_o = '0;
        if (sel_src == MemSrcData) begin
            mem_addr_o       = data_addr_i;
            mem_we_o         = data_we_i;
            mem_be_o         = data_be_i;
            mem_wdata_o      = data_wdata_i;
            mem_wdata_intg_o = data_wdata_intg_i;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (grant) begin
            last_d = sel_src;
            lock_d = 1'b0;
        end else if (mem_req_o) begin
            lock_d     = 1'b1;
            lock_src_d = sel_src;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= ResetLast;
            lock_q     <= 1'b0;
            lock_src_q <= MemSrcInstr;
            perr_q     <= 1'b0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            perr_q     <= perr_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    ibex_mem_arb_id_fifo #(
        .Depth   (MaxOutstanding),
        .entry_t (mem_src_e)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (grant),
        .push_data_i (sel_src),
        .pop_i       (resp_valid),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Responses during reset belong to transactions being flushed; drop them.
    assign resp_valid     = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign instr_rvalid_o = resp_valid & (fifo_head == MemSrcInstr);
    assign data_rvalid_o  = resp_valid & (fifo_head == MemSrcData);

    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign instr_err_o        = mem_err_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;
    assign data_err_o         = mem_err_i;

    assign perr_d         = perr_q | (mem_rvalid_i & fifo_empty & ~rst_i);
    assign protocol_err_o = perr_q & ~rst_i;

endmodule
